hazard_ctrl: RTL

//   Pipeline hazard controller (HDU) for the 5-stage RV32 core. Consumes the forwarding

---
 rtl/hazard_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush vectors and PC redirect.
// Optional perf counters behind HDU_PERF_CNT_EN.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   load_use_stall_i  load-use request from the forwarding unit
//   ex_busy_i         EX multicycle unit busy
//   mem_req_i         MEM stage data-bus access outstanding
//   mem_ready_i       data bus completes the access this cycle
//   branch_taken_i    EX resolved a taken branch/jump
//   branch_target_i   branch/jump target PC
//   trap_i            trap pulse from MEM/CSR
//   trap_vector_i     trap handler PC
//   stall_o           {pc, if_id, id_ex, ex_mem, mem_wb} hold
//   flush_o           {if_id, id_ex, ex_mem, mem_wb} bubble
//   redirect_o        PC loads redirect_pc_o
//   redirect_pc_o     new PC (0 when no redirect)
//   bus_err_o         one-cycle pulse on data-bus timeout
//   lu_cnt_o          load-use stall cycles
//   mw_cnt_o          mem-wait stall cycles
//   fl_cnt_o          redirect cycles
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_stall_i,
  input  logic                 ex_busy_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  input  logic                 branch_taken_i,
  input  logic [31:0]          branch_target_i,
  input  logic                 trap_i,
  input  logic [31:0]          trap_vector_i,
  output logic [4:0]           stall_o,
  output logic [3:0]           flush_o,
  output logic                 redirect_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 bus_err_o,
  output logic [CNT_WIDTH-1:0] lu_cnt_o,
  output logic [CNT_WIDTH-1:0] mw_cnt_o,
  output logic [CNT_WIDTH-1:0] fl_cnt_o
);

  localparam int TW =
    (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST =
    TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TRAP_PEND
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [31:0]   tvec, tvec_n;

  logic [4:0]  stall;
  logic [3:0]  flush;
  logic        redir;
  logic [31:0] rpc;
  logic        berr;

  logic mem_wait, pend, timeout;
  logic s_to, s_mw, s_pd, s_tr;
  logic s_bz, s_br, s_lu;

  assign mem_wait = mem_req_i & ~mem_ready_i;
  assign pend     = (state == TRAP_PEND);
  assign timeout  = mem_wait & (cnt == LAST);

  // One-hot selects encode the per-cycle priority.
  assign s_to = timeout;
  assign s_mw = mem_wait & ~timeout;
  assign s_pd = ~mem_wait & pend;
  assign s_tr = ~mem_wait & ~pend & trap_i;
  assign s_bz = ~mem_wait & ~pend & ~trap_i
              & ex_busy_i;
  assign s_br = ~mem_wait & ~pend & ~trap_i
              & ~ex_busy_i & branch_taken_i;
  assign s_lu = ~mem_wait & ~pend & ~trap_i
              & ~ex_busy_i & ~branch_taken_i
              & load_use_stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      tvec  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tvec  <= tvec_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tvec_n  = tvec;
    stall   = '0;
    flush   = '0;
    redir   = 1'b0;
    rpc     = '0;
    berr    = 1'b0;
    if (!mem_wait) begin
      state_n = RUN;
      cnt_n   = '0;
    end
    unique case (1'b1)
      s_to: begin
        berr    = 1'b1;
        flush   = 4'b0011;
        redir   = 1'b1;
        rpc     = pend ? tvec : trap_vector_i;
        state_n = RUN;
        cnt_n   = '0;
      end
      s_mw: begin
        stall = 5'b11110;
        flush = 4'b0001;
        cnt_n = cnt + 1'b1;
        // First trap wins; later ones in TRAP_PEND are dropped.
        if (!pend) begin
          state_n = MEM_WAIT;
          if (trap_i) begin
            state_n = TRAP_PEND;
            tvec_n  = trap_vector_i;
          end
        end
      end
      s_pd: begin
        flush = 4'b1110;
        redir = 1'b1;
        rpc   = tvec;
      end
      s_tr: begin
        flush = 4'b1110;
        redir = 1'b1;
        rpc   = trap_vector_i;
      end
      s_bz: begin
        stall = 5'b11100;
        flush = 4'b0010;
      end
      s_br: begin
        flush = 4'b1100;
        redir = 1'b1;
        rpc   = branch_target_i;
      end
      s_lu: begin
        stall = 5'b11000;
        flush = 4'b0100;
      end
      default: begin
        stall = '0;
      end
    endcase
  end

  assign stall_o       = rst ? '0 : stall;
  assign flush_o       = rst ? '0 : flush;
  assign redirect_o    = rst ? 1'b0 : redir;
  assign redirect_pc_o = rst ? '0 : rpc;
  assign bus_err_o     = rst ? 1'b0 : berr;

`ifdef HDU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] lu_q, mw_q, fl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q <= '0;
      mw_q <= '0;
      fl_q <= '0;
    end else begin
      if (s_lu && !(&lu_q))
        lu_q <= lu_q + 1'b1;
      if (s_mw && !(&mw_q))
        mw_q <= mw_q + 1'b1;
      if (redir && !(&fl_q))
        fl_q <= fl_q + 1'b1;
    end
  end

  assign lu_cnt_o = rst ? '0 : lu_q;
  assign mw_cnt_o = rst ? '0 : mw_q;
  assign fl_cnt_o = rst ? '0 : fl_q;
`else
  assign lu_cnt_o = '0;
  assign mw_cnt_o = '0;
  assign fl_cnt_o = '0;
`endif

endmodule
